clk_div_bank: RTL and testbench

Parametrised bank of independent programmable clock dividers, generalising the fixed single-channel 25-bit divider in the top-level skeleton. Each channel produces a 50%-duty divided level (`clkout`) and a one-cycle strobe (`tick`) in the `clock` domain. Divisors are runtime-writable through a valid/ready config port. The bank sits beside the processor in the top level and drives GPIO protocol and LED timing.

---
 rtl/clk_div_pkg.sv | 19 +
 rtl/clk_div_channel.sv | 65 ++++++
 rtl/clk_div_bank.sv | 103 ++++++++++
 tb/tb_clk_div_bank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank: reset divisor, config FSM
// state encoding and the channel-select width helper.
package clk_div_pkg;

    // Divisor loaded into every channel at reset (1 Hz tick from 25 MHz).
    localparam int DEFAULT_DIV_C = 24999999;

    // Config port state: IDLE accepts a write, APPLY finishes it.
    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_t;

    // Channel-select width: at least one bit even for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One programmable divider channel. Counts down from the divisor; at zero it
// reloads, toggles the divided level and raises a one-cycle tick.
// A config write (i_load) updates the divisor and, if it coincides with a
// terminal count, the reload already uses the new value. i_restart forces a
// phase-aligned restart from the stored divisor regardless of enable.
module clk_div_channel #(
    parameter int                 CNT_W     = 25,
    parameter logic [CNT_W-1:0]   RESET_DIV = '0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_div,
    input  logic             i_restart,
    output logic             o_tick,
    output logic             o_clkout
);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_clkout;
    logic [CNT_W-1:0] w_reload_div;

    // A write landing on a terminal count must reload with the new divisor,
    // never a mix of old and new.
    assign w_reload_div = i_load ? i_load_div : r_div;

    // Divisor storage, down-counter, divided level and tick strobe.
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values; blocking here would let r_cnt's update leak into r_tick's.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_div    <= RESET_DIV;
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_clkout <= 1'b0;
        end else begin
            if (i_load) begin
                r_div <= i_load_div;
            end
            if (i_restart) begin
                r_cnt    <= r_div;
                r_clkout <= 1'b0;
                r_tick   <= 1'b0;
            end else if (i_enable) begin
                if (r_cnt == '0) begin
                    r_cnt    <= w_reload_div;
                    r_clkout <= ~r_clkout;
                    r_tick   <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt - CNT_W'(1);
                    r_tick <= 1'b0;
                end
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign o_tick   = r_tick;
    assign o_clkout = r_clkout;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers with a two-state
// valid/ready config port. Writes to a channel index >= NUM_CH are accepted,
// dropped, and flagged by a one-cycle cfg_err pulse.
// Optional macro CLK_DIV_SYNC_RELOAD_EN: when defined, the cycle after a write
// restarts the target channel's count with the new divisor and clears its
// outputs; when undefined the new divisor takes effect at the next natural
// terminal count.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = 25,
    parameter int  DEFAULT_DIV = DEFAULT_DIV_C,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clkout
);

    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    cfg_state_t        r_state;
    logic              r_cfg_ready;
    logic              r_cfg_err;
    logic              w_accept;
    logic              w_ch_oob;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_restart;

    assign w_accept = cfg_valid & r_cfg_ready;
    assign w_ch_oob = ({1'b0, cfg_ch} >= NUM_CH_V);

    // Config FSM: accept in IDLE, spend one cycle in APPLY, flag bad indices.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= APPLY;
                        r_cfg_ready <= 1'b0;
                        r_cfg_err   <= w_ch_oob;
                    end
                end
                APPLY: begin
                    r_state     <= IDLE;
                    r_cfg_ready <= 1'b1;
                    r_cfg_err   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLK_DIV_SYNC_RELOAD_EN
    logic [NUM_CH-1:0] r_restart;

    // Remember which channel was written so APPLY can restart it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_restart <= '0;
        end else begin
            r_restart <= w_load;
        end
    end

    assign w_restart = r_restart;
`else
    assign w_restart = '0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_load[g] = w_accept & (cfg_ch == CH_W'(g));

        clk_div_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (CNT_W'(DEFAULT_DIV))
        ) u_channel (
            .i_clock    (clock),
            .i_reset    (reset),
            .i_enable   (ch_enable[g]),
            .i_load     (w_load[g]),
            .i_load_div (cfg_div),
            .i_restart  (w_restart[g]),
            .o_tick     (tick[g]),
            .o_clkout   (clkout[g])
        );
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (NUM_CH=3, CNT_W=8, DEFAULT_DIV=4).
// A reference model tracks, per channel, how many enabled edges have elapsed
// since the last terminal count and the period currently in force; it pushes
// the expected outputs for every edge into a queue that a negedge monitor
// drains and compares. Directed scenarios add constant-based checks.
module tb_clk_div_bank;

    localparam int N       = 3;
    localparam int DEF_DIV = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [7:0]   cfg_div = '0;
    logic [N-1:0] ch_enable = '1;
    logic         cfg_ready;
    logic         cfg_err;
    logic [N-1:0] tick;
    logic [N-1:0] clkout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N-1:0] tick;
        logic [N-1:0] clkout;
        logic         ready;
        logic         err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int div_m[N];
    int since_m[N];
    int per_m[N];
    bit lvl_m[N];
    bit tk_m[N];
    bit busy_m;
    bit err_m;
    int pend_m;

    clk_div_bank #(
        .NUM_CH      (N),
        .CNT_W       (8),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .ch_enable (ch_enable),
        .tick      (tick),
        .clkout    (clkout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            div_m[i]   = DEF_DIV;
            since_m[i] = 0;
            per_m[i]   = 1;   // counter starts at 0: terminal on first enabled edge
            lvl_m[i]   = 1'b0;
            tk_m[i]    = 1'b0;
        end
        busy_m = 1'b0;
        err_m  = 1'b0;
        pend_m = -1;
    endtask

    // Reference model: evaluate each edge from the spec's rules.
    initial begin
        exp_t e;
        bit   acc;
        int   ch;
        bit   tc;
        model_reset();
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                model_reset();
            end else begin
                acc = cfg_valid && !busy_m;
                ch  = int'(cfg_ch);
                for (int i = 0; i < N; i++) begin
                    tc = 1'b0;
                    if (acc && ch == i) div_m[i] = int'(cfg_div);
`ifdef CLK_DIV_SYNC_RELOAD_EN
                    if (busy_m && pend_m == i) begin
                        since_m[i] = 0;
                        per_m[i]   = div_m[i] + 1;
                        lvl_m[i]   = 1'b0;
                    end else
`endif
                    if (ch_enable[i]) begin
                        since_m[i]++;
                        if (since_m[i] == per_m[i]) begin
                            tc         = 1'b1;
                            since_m[i] = 0;
                            per_m[i]   = div_m[i] + 1;
                            lvl_m[i]   = !lvl_m[i];
                        end
                    end
                    tk_m[i] = tc;
                end
                busy_m = acc;
                pend_m = acc ? ch : -1;
                err_m  = acc && (ch >= N);
                for (int i = 0; i < N; i++) begin
                    e.tick[i]   = tk_m[i];
                    e.clkout[i] = lvl_m[i];
                end
                e.ready = !busy_m;
                e.err   = err_m;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the model's expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                exp_q.delete();
                check("rst_tick",   32'(tick),   32'h0);
                check("rst_clkout", 32'(clkout), 32'h0);
                check("rst_ready",  32'(cfg_ready), 32'h1);
                check("rst_err",    32'(cfg_err),   32'h0);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_tick",   32'(tick),      32'(e.tick));
                check("sb_clkout", 32'(clkout),    32'(e.clkout));
                check("sb_ready",  32'(cfg_ready), 32'(e.ready));
                check("sb_err",    32'(cfg_err),   32'(e.err));
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        cfg_valid = 1'b0;
        ch_enable = '1;
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        int accepts;

        // Reset release with all channels enabled; ch2 paused at cnt=2.
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k <= 12) begin
                check("a_tick0",   32'(tick[0]),   32'(k == 1 || k == 6 || k == 11));
                check("a_clkout0", 32'(clkout[0]), 32'(k <= 5 || k >= 11));
            end
            check("a_tick2",   32'(tick[2]),   32'(k == 1 || k == 13));
            check("a_clkout2", 32'(clkout[2]), 32'(k < 13));
            if (k == 3)  ch_enable[2] = 1'b0;
            if (k == 10) ch_enable[2] = 1'b1;
        end

        // ch1 divisor 0: continuous tick once it takes effect.
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0;
        step();
        cfg_valid = 1'b0;
        step();
        repeat (6) step();
        for (int k = 0; k < 4; k++) begin
            step();
            check("b_tick1_cont", 32'(tick[1]), 32'h1);
        end

        // Out-of-range channel write.
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
        step();
        check("c_err_pulse", 32'(cfg_err),   32'h1);
        check("c_ready_low", 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b0;
        step();
        check("c_err_clear", 32'(cfg_err),   32'h0);
        check("c_ready_back", 32'(cfg_ready), 32'h1);

        // Back-to-back requests: one accepted per two cycles.
        accepts   = 0;
        cfg_valid = 1'b1; cfg_ch = 2'd2;
        for (int j = 1; j <= 6; j++) begin
            cfg_div = 8'(2 * j - 1);
            if (cfg_ready) accepts++;
            step();
            check("d_ready_alt", 32'(cfg_ready), 32'(j % 2 == 0));
        end
        cfg_valid = 1'b0;
        check("d_accepts", 32'(accepts), 32'd3);

        // ch0 divisor 4 -> 9 written while its count is 3.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            step();
`ifdef CLK_DIV_SYNC_RELOAD_EN
            check("e_tick0", 32'(tick[0]), 32'(k == 1 || k == 14));
            if (k == 4) check("e_clkout0_restart", 32'(clkout[0]), 32'h0);
`else
            check("e_tick0", 32'(tick[0]), 32'(k == 1 || k == 6 || k == 16));
`endif
            if (k == 2) begin
                cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9;
            end
            if (k == 3) cfg_valid = 1'b0;
        end

        // Reset asserted during APPLY: immediate return to reset values.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1;
        step();
        cfg_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("f_tick_async",   32'(tick),      32'h0);
        check("f_clkout_async", 32'(clkout),    32'h0);
        check("f_ready_async",  32'(cfg_ready), 32'h1);
        check("f_err_async",    32'(cfg_err),   32'h0);
        @(negedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("f_tick0_default", 32'(tick[0]), 32'(k == 1 || k == 6));
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 800; k++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_div   = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0)
                ch_enable[$urandom_range(0, N - 1)] ^= 1'b1;
            step();
        end
        cfg_valid = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
